// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// around the datapath. It handshakes with instruction and data memory,
// freezes on stall, and parks in a sticky TRAP state on an illegal opcode.
//
// Optional build macro: MCU_PERF_CNT_EN adds a retired-instruction counter on
// instr_count. When it is undefined, instr_count is tied to zero and no
// counter flops are built.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   opcode                instruction opcode, sampled on imem_ack in FETCH
//   zero                  ALU zero flag (branch condition)
//   imem_ack, dmem_ack    memory handshakes
//   stall                 freeze the FSM and suppress strobes
//   imem_req, ir_load     instruction fetch request / IR load strobe
//   alu_control, alu_src  ALU operation and B-operand select
//   branch, pc_src        BEQ in EXECUTE / take branch target
//   pc_en, reg_write      PC update and register-file write strobes
//   mem_read, mem_write   data memory requests
//   illegal               sticky illegal-opcode trap
//   state_o               FSM state (FETCH=0 .. TRAP=5)
//   instr_count           retired instruction count
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUCTL_W = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                stall,
  output logic                imem_req,
  output logic                ir_load,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                alu_src,
  output logic                branch,
  output logic                pc_src,
  output logic                pc_en,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                illegal,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    instr_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_ADDI  = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_STORE = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;

  state_t              r_state;
  state_t              w_next_state;
  logic [OPCODE_W-1:0] r_op_q;

  logic [3:0] w_op_lo;
  logic       w_op_illegal;
  logic       w_is_beq;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_imm;
  logic [1:0] w_alu_op;

  logic                w_imem_req;
  logic                w_ir_load;
  logic                w_alu_active;
  logic [ALUCTL_W-1:0] w_alu_control;
  logic                w_alu_src;
  logic                w_branch;
  logic                w_pc_src;
  logic                w_pc_en;
  logic                w_reg_write;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_illegal;

  // Decode of the latched opcode; any set bit above the low nibble is illegal.
  assign w_op_lo      = r_op_q[3:0];
  assign w_op_illegal = ((r_op_q >> 4) != '0) || w_op_lo[3];
  assign w_is_beq     = (w_op_lo == OP_BEQ);
  assign w_is_load    = (w_op_lo == OP_LOAD);
  assign w_is_store   = (w_op_lo == OP_STORE);
  assign w_is_imm     = (w_op_lo == OP_ADDI) || w_is_load || w_is_store;

  always_comb begin
    w_alu_op = 2'd0;
    case (w_op_lo)
      OP_SUB, OP_BEQ: w_alu_op = 2'd1;
      OP_AND:         w_alu_op = 2'd2;
      OP_OR:          w_alu_op = 2'd3;
      default:        w_alu_op = 2'd0;
    endcase
  end

  // State register and opcode latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_ir_load) begin
        r_op_q <= opcode;
      end
    end
  end

  // Next-state and control outputs. Stall holds the state and drops only the
  // one-shot strobes; request levels and ALU controls stay put.
  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_ir_load    = 1'b0;
    w_alu_active = 1'b0;
    w_branch     = 1'b0;
    w_pc_src     = 1'b0;
    w_pc_en      = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_illegal    = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_ack && !stall) begin
          w_ir_load    = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!stall) begin
          w_next_state = w_op_illegal ? S_TRAP : S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        w_alu_active = 1'b1;
        w_branch     = w_is_beq;
        w_pc_src     = w_is_beq && zero;
        if (!stall) begin
          if (w_is_beq) begin
            w_pc_en      = 1'b1;
            w_next_state = S_FETCH;
          end else if (w_is_load || w_is_store) begin
            w_next_state = S_MEM;
          end else begin
            w_next_state = S_WRITEBACK;
          end
        end
      end
      S_MEM: begin
        w_alu_active = 1'b1;
        w_mem_read   = w_is_load;
        w_mem_write  = w_is_store;
        if (dmem_ack && !stall) begin
          if (w_is_load) begin
            w_next_state = S_WRITEBACK;
          end else begin
            w_pc_en      = 1'b1;
            w_next_state = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        w_alu_active = 1'b1;
        if (!stall) begin
          w_reg_write  = 1'b1;
          w_pc_en      = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase

    w_alu_control = w_alu_active ? ALUCTL_W'(w_alu_op) : '0;
    w_alu_src     = w_alu_active && w_is_imm;
  end

  // Every output reads zero while reset is asserted.
  assign imem_req    = rst_n && w_imem_req;
  assign ir_load     = rst_n && w_ir_load;
  assign alu_control = rst_n ? w_alu_control : '0;
  assign alu_src     = rst_n && w_alu_src;
  assign branch      = rst_n && w_branch;
  assign pc_src      = rst_n && w_pc_src;
  assign pc_en       = rst_n && w_pc_en;
  assign reg_write   = rst_n && w_reg_write;
  assign mem_read    = rst_n && w_mem_read;
  assign mem_write   = rst_n && w_mem_write;
  assign illegal     = rst_n && w_illegal;
  assign state_o     = rst_n ? 3'(r_state) : 3'd0;

`ifdef MCU_PERF_CNT_EN
  logic [CNT_W-1:0] r_instr_count;

  // pc_en fires exactly once per retired instruction and never when stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr_count <= '0;
    end else if (w_pc_en) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign instr_count = rst_n ? r_instr_count : '0;
`else
  assign instr_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (OPCODE_W=5, ALUCTL_W=3,
// CNT_W=2). A per-instruction phase schedule model predicts every output each
// cycle; directed tables and sequences cover the documented corner cases.
module tb_multicycle_control_unit;

  localparam int unsigned OW = 5;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic [OW-1:0] opcode;
  logic          zero;
  logic          imem_ack;
  logic          dmem_ack;
  logic          stall;
  logic          imem_req;
  logic          ir_load;
  logic [AW-1:0] alu_control;
  logic          alu_src;
  logic          branch;
  logic          pc_src;
  logic          pc_en;
  logic          reg_write;
  logic          mem_read;
  logic          mem_write;
  logic          illegal;
  logic [2:0]    state_o;
  logic [CW-1:0] instr_count;

  multicycle_control_unit #(.OPCODE_W(OW), .ALUCTL_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .stall(stall),
    .imem_req(imem_req), .ir_load(ir_load), .alu_control(alu_control),
    .alu_src(alu_src), .branch(branch), .pc_src(pc_src), .pc_en(pc_en),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .illegal(illegal), .state_o(state_o), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // An instruction is a fixed list of phases (state numbers); the model keeps
  // the index into that list and the latched opcode.
  int m_idx = 0;
  int m_op  = 0;
  int m_cnt = 0;
  int alu_tab [8] = '{0, 1, 2, 3, 0, 0, 0, 1};

  function automatic bit op_bad(input int op);
    return ((op >> 4) != 0) || ((op & 8) != 0);
  endfunction

  function automatic int sched_len(input int op);
    if (op_bad(op)) return 1000;
    if (op == 7) return 3;
    if (op == 5) return 5;
    return 4;
  endfunction

  function automatic int phase_of(input int op, input int idx);
    if (idx == 0) return 0;
    if (idx == 1) return 1;
    if (op_bad(op)) return 5;
    if (idx == 2) return 2;
    if (idx == 3) return (op == 5 || op == 6) ? 3 : 4;
    return 4;
  endfunction

  // Last sampled DUT outputs, for the directed sequences.
  logic [2:0]    s_state;
  logic          s_imem, s_ir, s_mr, s_mw, s_pc, s_rw, s_br, s_ps, s_src, s_ill;
  logic [AW-1:0] s_alu;
  logic [CW-1:0] s_cnt;

  // One clock: drive at negedge, compare against the model, advance at posedge.
  task automatic step(input logic rn, input logic st, input logic ia,
                      input logic da, input logic z, input logic [OW-1:0] opc);
    int ph;
    bit last;
    bit in_alu;
    logic [2:0]    e_state;
    logic          e_imem, e_ir, e_mr, e_mw, e_pc, e_rw, e_br, e_ps, e_src, e_ill;
    logic [AW-1:0] e_alu;
    logic [CW-1:0] e_cnt;
    @(negedge clk);
    rst_n = rn; stall = st; imem_ack = ia; dmem_ack = da; zero = z; opcode = opc;
    #1;
    ph     = phase_of(m_op, m_idx);
    last   = (m_idx == sched_len(m_op) - 1);
    in_alu = (ph >= 2) && (ph <= 4);
    e_state = 3'(ph);
    e_imem  = (ph == 0);
    e_ir    = (ph == 0) && ia && !st;
    e_mr    = (ph == 3) && (m_op == 5);
    e_mw    = (ph == 3) && (m_op == 6);
    e_pc    = !st && last && ((ph != 3) || da);
    e_rw    = !st && (ph == 4);
    e_br    = (ph == 2) && (m_op == 7);
    e_ps    = e_br && z;
    e_alu   = in_alu ? AW'(alu_tab[m_op & 7]) : '0;
    e_src   = in_alu && (m_op == 4 || m_op == 5 || m_op == 6);
    e_ill   = (ph == 5);
`ifdef MCU_PERF_CNT_EN
    e_cnt   = CW'(m_cnt);
`else
    e_cnt   = '0;
`endif
    if (!rn) begin
      e_state = '0; e_imem = 0; e_ir = 0; e_mr = 0; e_mw = 0; e_pc = 0; e_rw = 0;
      e_br = 0; e_ps = 0; e_alu = '0; e_src = 0; e_ill = 0; e_cnt = '0;
    end
    s_state = state_o; s_imem = imem_req; s_ir = ir_load; s_mr = mem_read;
    s_mw = mem_write; s_pc = pc_en; s_rw = reg_write; s_br = branch; s_ps = pc_src;
    s_alu = alu_control; s_src = alu_src; s_ill = illegal; s_cnt = instr_count;
    chk("model", 32'({s_state, s_imem, s_ir, s_mr, s_mw, s_pc, s_rw, s_br, s_ps,
                      s_alu, s_src, s_ill, s_cnt}),
                 32'({e_state, e_imem, e_ir, e_mr, e_mw, e_pc, e_rw, e_br, e_ps,
                      e_alu, e_src, e_ill, e_cnt}));
    @(posedge clk);
    cyc++;
    if (!rn) begin
      m_idx = 0; m_op = 0; m_cnt = 0;
    end else if (!st && ph != 5 && !((ph == 0 && !ia) || (ph == 3 && !da))) begin
      if (ph == 0) m_op = int'(opc);
      if (m_idx == sched_len(m_op) - 1) begin
        m_idx = 0;
        m_cnt = (m_cnt + 1) % 4;
      end else begin
        m_idx++;
      end
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          rn, st, ia, da, z;
    logic [OW-1:0] opc;
    logic [2:0]    e_state;
    logic          e_imem, e_ir, e_pc, e_rw, e_br, e_ps;
    logic [AW-1:0] e_alu;
  } vec_t;

  vec_t tbl [12];

  int ph_now;
  int n_mem, n_mr, n_rw, n_mw, n_cyc, n_st;
  bit src_ok, gap, seen_mw, done;
  int exp_seq [5];

  initial begin
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0;
    opcode = '0;

    //            rn st ia da z  opc   state imem ir pc rw br ps alu
    tbl[0]  = '{0, 0, 0, 0, 0, 5'd0, 3'd0, 0, 0, 0, 0, 0, 0, 3'd0};
    tbl[1]  = '{1, 0, 1, 0, 0, 5'd0, 3'd0, 1, 1, 0, 0, 0, 0, 3'd0};
    tbl[2]  = '{1, 0, 0, 0, 0, 5'd0, 3'd1, 0, 0, 0, 0, 0, 0, 3'd0};
    tbl[3]  = '{1, 0, 0, 0, 0, 5'd0, 3'd2, 0, 0, 0, 0, 0, 0, 3'd0};
    tbl[4]  = '{1, 0, 0, 0, 0, 5'd0, 3'd4, 0, 0, 1, 1, 0, 0, 3'd0};
    tbl[5]  = '{1, 0, 1, 0, 1, 5'd7, 3'd0, 1, 1, 0, 0, 0, 0, 3'd0};
    tbl[6]  = '{1, 0, 0, 0, 1, 5'd0, 3'd1, 0, 0, 0, 0, 0, 0, 3'd0};
    tbl[7]  = '{1, 0, 0, 0, 1, 5'd0, 3'd2, 0, 0, 1, 0, 1, 1, 3'd1};
    tbl[8]  = '{1, 0, 1, 0, 0, 5'd7, 3'd0, 1, 1, 0, 0, 0, 0, 3'd0};
    tbl[9]  = '{1, 0, 0, 0, 0, 5'd0, 3'd1, 0, 0, 0, 0, 0, 0, 3'd0};
    tbl[10] = '{1, 0, 0, 0, 0, 5'd0, 3'd2, 0, 0, 1, 0, 1, 0, 3'd1};
    tbl[11] = '{1, 0, 0, 0, 0, 5'd3, 3'd0, 1, 0, 0, 0, 0, 0, 3'd0};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rn, tbl[i].st, tbl[i].ia, tbl[i].da, tbl[i].z, tbl[i].opc);
      chk($sformatf("tbl[%0d]", i),
          32'({s_state, s_imem, s_ir, s_pc, s_rw, s_br, s_ps, s_alu}),
          32'({tbl[i].e_state, tbl[i].e_imem, tbl[i].e_ir, tbl[i].e_pc,
               tbl[i].e_rw, tbl[i].e_br, tbl[i].e_ps, tbl[i].e_alu}));
    end

    // LOAD with dmem_ack arriving on the 4th MEM cycle.
    step(0, 0, 0, 0, 0, '0);
    n_mem = 0; n_mr = 0; n_rw = 0; n_cyc = 0; src_ok = 1; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1, 0, (i == 0), (n_mem >= 3), 0, 5'd5);
      n_cyc++;
      if (s_state == 3'd3) begin
        n_mem++;
        if (!s_src) src_ok = 0;
      end
      if (s_mr) n_mr++;
      if (s_rw) n_rw++;
      if (s_pc) done = 1;
    end
    chk("load_cycles", 32'(n_cyc), 32'd8);
    chk("load_mem_read_cycles", 32'(n_mr), 32'd4);
    chk("load_reg_write", 32'(n_rw), 32'd1);
    chk("load_alu_src", 32'(src_ok), 32'd1);

    // STORE stalled for two MEM cycles with dmem_ack already high.
    n_mw = 0; n_cyc = 0; n_st = 0; gap = 0; seen_mw = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      ph_now = phase_of(m_op, m_idx);
      step(1, (ph_now == 3 && n_st < 2), (i == 0), 1, 0, 5'd6);
      if (stall) n_st++;
      n_cyc++;
      if (s_mw) begin
        n_mw++;
        seen_mw = 1;
      end else if (seen_mw) begin
        gap = 1;
      end
      if (s_pc) done = 1;
    end
    chk("store_cycles", 32'(n_cyc), 32'd6);
    chk("store_mem_write_cycles", 32'(n_mw), 32'd3);
    chk("store_no_gap", 32'(gap), 32'd0);

    // Illegal opcodes: low nibble 9, upper bit set, low nibble 8.
    for (int k = 0; k < 3; k++) begin
      logic [OW-1:0] bad_op;
      bad_op = (k == 0) ? 5'b01001 : ((k == 1) ? 5'b10000 : 5'b01000);
      step(1, 0, 0, 0, 0, '0);
      step(1, 0, 1, 0, 0, bad_op);
      step(1, 0, 0, 0, 0, '0);
      for (int j = 0; j < 4; j++) begin
        step(1, 0, 1, 1, 1, 5'd0);
        chk($sformatf("trap_state[%0d]", k), 32'(s_state), 32'd5);
        chk($sformatf("trap_illegal[%0d]", k), 32'(s_ill), 32'd1);
      end
      step(0, 0, 1, 1, 0, '0);
      chk($sformatf("trap_reset_illegal[%0d]", k), 32'(s_ill), 32'd0);
      step(1, 0, 0, 0, 0, '0);
      chk($sformatf("trap_exit_state[%0d]", k), 32'(s_state), 32'd0);
      chk($sformatf("trap_exit_illegal[%0d]", k), 32'(s_ill), 32'd0);
    end

    // Counter sequence over five retired ADDs.
`ifdef MCU_PERF_CNT_EN
    exp_seq = '{1, 2, 3, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    step(0, 0, 0, 0, 0, '0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 0, 0, 5'd0);
      step(1, 0, 0, 0, 0, 5'd0);
      step(1, 0, 0, 0, 0, 5'd0);
      step(1, 0, 0, 0, 0, 5'd0);
      step(1, 0, 0, 0, 0, 5'd0);
      chk($sformatf("instr_count[%0d]", k), 32'(s_cnt), 32'(exp_seq[k]));
    end

    // Randomized traffic against the model.
    step(0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4000; i++) begin
      logic [OW-1:0] r_opc;
      r_opc = (($urandom % 16) == 0) ? OW'($urandom) : OW'($urandom % 8);
      step((($urandom % 64) != 0), (($urandom % 4) == 0), 1'($urandom),
           1'($urandom), 1'($urandom), r_opc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised successor to the single-cycle decoder. It turns the combinational opcode→control mapping into a multi-cycle FSM that sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It handshakes with instruction and data memory, accepts a pipeline-style stall, and traps illegal opcodes. It sits between the instruction register and the datapath (ALU, register file, PC, memories) of the microprocessor.

Parameters:
OPCODE_W, 4, opcode width; bits above [3:0] must be zero or the opcode is illegal (OPCODE_W >= 4)
ALUCTL_W, 2, alu_control width; encodings below are zero-extended (ALUCTL_W >= 2)
CNT_W, 32, width of the retired-instruction counter (optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  OPCODE_W  instruction opcode, sampled only on imem_ack in FETCH
zero  in  1  ALU zero flag
imem_ack  in  1  instruction memory data valid
dmem_ack  in  1  data memory access complete
stall  in  1  freeze FSM
imem_req  out  1  instruction fetch request
ir_load  out  1  load instruction register
alu_control  out  ALUCTL_W  ALU op: ADD=0, SUB=1, AND=2, OR=3
alu_src  out  1  ALU B operand = immediate
branch  out  1  instruction is BEQ
pc_src  out  1  branch & zero (take branch target)
pc_en  out  1  PC update strobe
reg_write  out  1  register file write strobe
mem_read  out  1  data memory read request
mem_write  out  1  data memory write request
illegal  out  1  sticky illegal-opcode trap
state_o  out  3  FSM state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5
instr_count  out  CNT_W  retired instructions (see Optional Feature)

Behaviour:
- Opcode map (low 4 bits): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LOAD, 6 STORE, 7 BEQ.
- Illegal: low nibble 8–15, or any nonzero upper bit.
- rst_n low at a clock edge: state=FETCH, op_q=0, illegal=0, instr_count=0. While rst_n is low, all outputs are forced 0. Reset mid-instruction aborts it; no strobe fires.
- Outputs are combinational from state and op_q, where op_q is the opcode latched on the FETCH ack.
- FETCH: imem_req=1 until imem_ack. In the ack cycle: ir_load=1, op_q<=opcode, next state DECODE.
- DECODE: 1 cycle. Illegal op_q → TRAP; otherwise → EXECUTE.
- EXECUTE: 1 cycle.
  - alu_control: ADD/ADDI/LOAD/STORE=0, SUB/BEQ=1, AND=2, OR=3.
  - alu_src=1 for ADDI/LOAD/STORE.
  - BEQ: branch=1, pc_src=zero, pc_en=1, retire, → FETCH.
  - LOAD/STORE → MEM.
  - Others → WRITEBACK.
- MEM: alu outputs are held as in EXECUTE.
  - LOAD: mem_read=1 until dmem_ack, then → WRITEBACK.
  - STORE: mem_write=1 until dmem_ack; in the ack cycle pc_en=1, retire, → FETCH.
- WRITEBACK: 1 cycle. reg_write=1, pc_en=1, alu outputs held, retire, → FETCH.
- TRAP: illegal=1 and all strobes 0. Exit only by reset.
- Latency with acks in the first cycle: R/ADDI 4 cycles, BEQ 3, STORE 4, LOAD 5.
- stall=1:
  - state and op_q hold.
  - ir_load, pc_en, reg_write forced 0, and acks are ignored that cycle.
  - imem_req, mem_read, mem_write and ALU controls keep their level.
  - stall has priority over acks arriving in the same cycle.
- Ack in a state that does not request it: ignored.

Optional Feature:
- Macro: MCU_PERF_CNT_EN.
- Defined: instr_count increments by 1 on each retire (BEQ in EXECUTE, STORE ack, WRITEBACK) with stall=0. It wraps modulo 2^CNT_W, resets to 0, and does not count in TRAP.
- Undefined: instr_count is tied to 0 and no counter flops are built.

Test Plan:
- Reset then ADD (opcode=0), acks immediate → states 0,1,2,4,0; alu_control=0; reg_write and pc_en high in state 4 only; instr_count=1.
- BEQ (opcode=7) with zero=1, then BEQ with zero=0 → in EXECUTE branch=1, alu_control=1, pc_en=1 both times; pc_src=1 then 0; no reg_write.
- LOAD (opcode=5) with dmem_ack delayed 3 cycles → mem_read high 4 cycles, alu_src=1; WRITEBACK reg_write=1; total 8 cycles.
- STORE (opcode=6) with stall=1 for 2 cycles in MEM while dmem_ack=1 → ack ignored while stalled; pc_en pulses once after stall drops; mem_write never gaps.
- opcode=4'b1001, then opcode=8 with OPCODE_W=5 → TRAP (state_o=5), illegal=1 sticky; rst_n=0 for 1 cycle clears it and returns to FETCH.
- With MCU_PERF_CNT_EN and CNT_W=2, retire 5 instructions → instr_count 1,2,3,0,1. Without the macro → instr_count constant 0.
